// File: rtl/dm_pkg.sv
// Shared types and widths for the data-memory responder.
// Macro DM_CLEAR_EN adds the post-reset CLEAR state.
package dm_pkg;

  localparam int DATA_W = 32;
  localparam int WCNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_RESP  = 2'd2
`ifdef DM_CLEAR_EN
    ,
    ST_CLEAR = 2'd3
`endif
  } dm_state_t;

endpackage

// File: rtl/dm_sram.sv
// Single-write, single synchronous-read word array; the contents are never reset.
module dm_sram
  import dm_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder: accepts one request at a time, optional wait states, one-cycle ready pulse.
// Macro DM_CLEAR_EN: zero the whole array after every reset before accepting requests.
module dm_responder
  import dm_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        DM_enable,
  input  logic        DM_read,
  input  logic        DM_write,
  input  logic [11:0] DM_address,
  input  logic [31:0] DM_in,
  output logic [31:0] DM_out,
  output logic        DM_ready,
  output logic        DM_busy
);

  localparam logic [WCNT_W-1:0] WAIT_INIT = WCNT_W'(WAIT_STATES - 1);
`ifdef DM_CLEAR_EN
  localparam dm_state_t RESET_STATE = ST_CLEAR;
`else
  localparam dm_state_t RESET_STATE = ST_IDLE;
`endif

  dm_state_t           state_reg, state_next;
  logic [WCNT_W-1:0]   wait_cnt_reg, wait_cnt_next;
  logic                req_read_reg, req_read_next;
  logic [ADDR_W-1:0]   req_addr_reg, req_addr_next;
  logic [DATA_W-1:0]   out_reg;

  logic [ADDR_W-1:0]   addr_in;
  logic                accept, accept_write, accept_read;
  logic                wr_en, rd_en;
  logic [ADDR_W-1:0]   wr_addr, rd_addr;
  logic [DATA_W-1:0]   wr_data, rd_data;

  assign addr_in      = DM_address[ADDR_W-1:0];
  assign accept       = (state_reg == ST_IDLE) && DM_enable && (DM_read || DM_write);
  assign accept_write = accept && DM_write;
  assign accept_read  = accept && !DM_write;

`ifdef DM_CLEAR_EN
  logic [ADDR_W-1:0] clr_cnt_reg;
  logic              clearing;

  assign clearing = (state_reg == ST_CLEAR);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          clr_cnt_reg <= '0;
    else if (clearing) clr_cnt_reg <= clr_cnt_reg + ADDR_W'(1);
  end

  assign wr_en   = clearing || accept_write;
  assign wr_addr = clearing ? clr_cnt_reg : addr_in;
  assign wr_data = clearing ? '0 : DM_in;
`else
  assign wr_en   = accept_write;
  assign wr_addr = addr_in;
  assign wr_data = DM_in;
`endif

  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    req_read_next = req_read_reg;
    req_addr_next = req_addr_reg;
    DM_ready      = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          req_read_next = accept_read;
          req_addr_next = addr_in;
          if (WAIT_STATES > 0) begin
            state_next    = ST_WAIT;
            wait_cnt_next = WAIT_INIT;
          end else begin
            state_next = ST_RESP;
          end
        end
      end
      ST_WAIT: begin
        if (wait_cnt_reg == '0) state_next = ST_RESP;
        else                    wait_cnt_next = wait_cnt_reg - WCNT_W'(1);
      end
      ST_RESP: begin
        DM_ready   = 1'b1;
        state_next = ST_IDLE;
      end
`ifdef DM_CLEAR_EN
      ST_CLEAR: begin
        if (clr_cnt_reg == '1) state_next = ST_IDLE;
      end
`endif
      default: state_next = ST_IDLE;
    endcase
  end

  // The array read is issued on the edge entering RESP so the word is available throughout RESP.
  assign rd_en   = (state_next == ST_RESP) &&
                   ((state_reg == ST_IDLE) ? accept_read : req_read_reg);
  assign rd_addr = (state_reg == ST_IDLE) ? addr_in : req_addr_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= RESET_STATE;
      wait_cnt_reg <= '0;
      req_read_reg <= 1'b0;
      req_addr_reg <= '0;
      out_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      req_read_reg <= req_read_next;
      req_addr_reg <= req_addr_next;
      if (state_reg == ST_RESP && req_read_reg) out_reg <= rd_data;
    end
  end

  // During a read's RESP cycle the fresh word is shown; otherwise the last completed read is held.
  assign DM_out  = (state_reg == ST_RESP && req_read_reg) ? rd_data : out_reg;
  assign DM_busy = (state_reg != ST_IDLE);

  dm_sram #(
    .ADDR_W (ADDR_W)
  ) u_sram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_dm_responder.sv
// Scoreboard bench for dm_responder: three instances with different ADDR_W / WAIT_STATES.
// Honours DM_CLEAR_EN when the build defines it.
module tb_dm_responder;

  typedef struct {
    int          unit;
    logic [31:0] data;
  } exp_t;

  logic        clk;
  logic        rst   [3];
  logic        en    [3];
  logic        rd    [3];
  logic        wr    [3];
  logic [11:0] addr  [3];
  logic [31:0] din   [3];
  logic [31:0] dout  [3];
  logic        ready [3];
  logic        busy  [3];

  int          vectors     = 0;
  int          miscompares = 0;
  exp_t        exp_q[$];
  logic [31:0] exp_out [3];

  dm_responder #(.ADDR_W(8), .WAIT_STATES(0)) u0 (
    .clk(clk), .rst(rst[0]), .DM_enable(en[0]), .DM_read(rd[0]), .DM_write(wr[0]),
    .DM_address(addr[0]), .DM_in(din[0]), .DM_out(dout[0]), .DM_ready(ready[0]), .DM_busy(busy[0]));

  dm_responder #(.ADDR_W(12), .WAIT_STATES(3)) u1 (
    .clk(clk), .rst(rst[1]), .DM_enable(en[1]), .DM_read(rd[1]), .DM_write(wr[1]),
    .DM_address(addr[1]), .DM_in(din[1]), .DM_out(dout[1]), .DM_ready(ready[1]), .DM_busy(busy[1]));

  dm_responder #(.ADDR_W(4), .WAIT_STATES(2)) u2 (
    .clk(clk), .rst(rst[2]), .DM_enable(en[2]), .DM_read(rd[2]), .DM_write(wr[2]),
    .DM_address(addr[2]), .DM_in(din[2]), .DM_out(dout[2]), .DM_ready(ready[2]), .DM_busy(busy[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int ws_of(input int u);
    return (u == 0) ? 0 : (u == 1) ? 3 : 2;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every ready pulse must match the oldest expected response.
  initial begin
    forever begin
      @(negedge clk);
      for (int u = 0; u < 3; u++) begin
        if (ready[u] === 1'b1) begin
          if (exp_q.size() == 0) begin
            check($sformatf("unexpected_ready_u%0d", u), 32'd1, 32'd0);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            check($sformatf("ready_unit_u%0d", u), u, e.unit);
            check($sformatf("dm_out_u%0d", u), dout[u], e.data);
            $display("resp u%0d: DM_out=%h expected=%h", u, dout[u], e.data);
          end
        end
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_idle(input int u, input int bound);
    int n = 0;
    while (busy[u] === 1'b1 && n < bound) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("idle_u%0d", u), busy[u], 1'b0);
  endtask

  task automatic req(input int u, input bit r, input bit w, input logic [11:0] a,
                     input logic [31:0] d, input logic [31:0] rd_exp, input string tag);
    int ws = ws_of(u);
    int busy_n = 0, rdy_at = 0, rdy_n = 0;
    if (w) exp_q.push_back('{u, exp_out[u]});
    else begin
      exp_out[u] = rd_exp;
      exp_q.push_back('{u, rd_exp});
    end
    @(posedge clk); #1;
    en[u] = 1'b1; rd[u] = r; wr[u] = w; addr[u] = a; din[u] = d;
    @(posedge clk); #1;
    en[u] = 1'b0; rd[u] = 1'b0; wr[u] = 1'b0;
    for (int k = 1; k <= ws + 2; k++) begin
      @(negedge clk);
      if (busy[u] === 1'b1) busy_n++;
      if (ready[u] === 1'b1) begin
        rdy_n++;
        rdy_at = k;
      end
    end
    check({tag, "_busy_cycles"}, busy_n, ws + 1);
    check({tag, "_ready_cycle"}, rdy_at, ws + 1);
    check({tag, "_ready_count"}, rdy_n, 1);
    $display("req u%0d %s: r=%0b w=%0b addr=%h din=%h ready@%0d busy=%0d",
             u, tag, r, w, a, d, rdy_at, busy_n);
  endtask

  initial begin
    int n;
    int first_rdy, second_rdy, busy_n, rdy_n;
    for (int u = 0; u < 3; u++) begin
      rst[u] = 1'b0; en[u] = 1'b0; rd[u] = 1'b0; wr[u] = 1'b0;
      addr[u] = '0; din[u] = '0; exp_out[u] = '0;
    end
    repeat (3) @(negedge clk);
    for (int u = 0; u < 3; u++) begin
      check($sformatf("rst_dm_out_u%0d", u), dout[u], 32'd0);
      check($sformatf("rst_ready_u%0d", u), ready[u], 1'b0);
`ifdef DM_CLEAR_EN
      check($sformatf("rst_busy_u%0d", u), busy[u], 1'b1);
`else
      check($sformatf("rst_busy_u%0d", u), busy[u], 1'b0);
`endif
    end
    @(posedge clk); #1;
    for (int u = 0; u < 3; u++) rst[u] = 1'b1;

`ifdef DM_CLEAR_EN
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (busy[2] === 1'b1) n++;
      else break;
    end
    check("clear_busy_cycles_u2", n, 16);
    wait_idle(0, 400);
    wait_idle(1, 5000);
    req(2, 1'b1, 1'b0, 12'h007, 32'h0, 32'h0, "clear_rd007");
`else
    @(negedge clk);
    for (int u = 0; u < 3; u++) check($sformatf("idle_after_rst_u%0d", u), busy[u], 1'b0);
`endif

    // Unit 0: ADDR_W=8, no wait states
    req(0, 1'b0, 1'b1, 12'h010, 32'hDEADBEEF, 32'h0, "wr010");
    req(0, 1'b1, 1'b0, 12'h010, 32'h0, 32'hDEADBEEF, "rd010");
    @(posedge clk); #1;
    en[0] = 1'b0; rd[0] = 1'b1; wr[0] = 1'b1; addr[0] = 12'h010; din[0] = 32'h0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("enable_low_busy", busy[0], 1'b0);
    end
    @(posedge clk); #1;
    rd[0] = 1'b0; wr[0] = 1'b0;
    req(0, 1'b1, 1'b1, 12'h020, 32'h12345678, 32'h0, "rdwr020");
    req(0, 1'b1, 1'b0, 12'h020, 32'h0, 32'h12345678, "rd020");
    req(0, 1'b0, 1'b1, 12'h105, 32'hA5A5A5A5, 32'h0, "wr105");
    req(0, 1'b1, 1'b0, 12'h005, 32'h0, 32'hA5A5A5A5, "rd005");
    req(0, 1'b0, 1'b1, 12'h0FF, 32'h11111111, 32'h0, "wr0ff");
    req(0, 1'b1, 1'b0, 12'h1FF, 32'h0, 32'h11111111, "rd1ff");
    req(0, 1'b1, 1'b0, 12'h010, 32'h0, 32'hDEADBEEF, "rd010b");

    // Unit 1: three wait states
    req(1, 1'b0, 1'b1, 12'hABC, 32'hCAFEF00D, 32'h0, "wrabc");
    req(1, 1'b1, 1'b0, 12'hABC, 32'h0, 32'hCAFEF00D, "rdabc");
    req(1, 1'b0, 1'b1, 12'hFFF, 32'h0BADC0DE, 32'h0, "wrfff");
    req(1, 1'b1, 1'b0, 12'hFFF, 32'h0, 32'h0BADC0DE, "rdfff");
    req(1, 1'b1, 1'b0, 12'hABC, 32'h0, 32'hCAFEF00D, "rdabcb");

    // Unit 2: read held while a write is in flight; accepted only once back in IDLE
    exp_q.push_back('{2, exp_out[2]});
    exp_out[2] = 32'h5A5A0001;
    exp_q.push_back('{2, 32'h5A5A0001});
    @(posedge clk); #1;
    en[2] = 1'b1; wr[2] = 1'b1; rd[2] = 1'b0; addr[2] = 12'h001; din[2] = 32'h5A5A0001;
    @(posedge clk); #1;
    wr[2] = 1'b0; rd[2] = 1'b1; din[2] = 32'h0;
    first_rdy = 0; second_rdy = 0; busy_n = 0; rdy_n = 0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (busy[2] === 1'b1) busy_n++;
      if (ready[2] === 1'b1) begin
        rdy_n++;
        if (first_rdy == 0) first_rdy = k;
        else second_rdy = k;
      end
      if (k == 5) begin
        en[2] = 1'b0; rd[2] = 1'b0;
      end
    end
    check("hold_first_ready", first_rdy, 3);
    check("hold_second_ready", second_rdy, 7);
    check("hold_busy_cycles", busy_n, 6);
    check("hold_ready_count", rdy_n, 2);
    $display("hold u2: ready@%0d and @%0d busy=%0d", first_rdy, second_rdy, busy_n);

    // Unit 2: reset during WAIT aborts the read
    @(posedge clk); #1;
    en[2] = 1'b1; rd[2] = 1'b1; addr[2] = 12'h001;
    @(posedge clk); #1;
    en[2] = 1'b0; rd[2] = 1'b0;
    @(negedge clk);
    check("abort_busy_in_wait", busy[2], 1'b1);
    rst[2] = 1'b0;
    @(negedge clk);
    check("abort_dm_out_in_rst", dout[2], 32'h0);
    check("abort_ready_in_rst", ready[2], 1'b0);
    repeat (2) @(posedge clk);
    #1 rst[2] = 1'b1;
    exp_out[2] = 32'h0;
    wait_idle(2, 100);
    repeat (6) @(negedge clk);
    check("abort_dm_out_after", dout[2], 32'h0);
    $display("abort u2: DM_out=%h after reset in WAIT", dout[2]);
`ifdef DM_CLEAR_EN
    req(2, 1'b1, 1'b0, 12'h001, 32'h0, 32'h0, "post_rst_rd001");
`else
    req(2, 1'b1, 1'b0, 12'h001, 32'h0, 32'h5A5A0001, "post_rst_rd001");
`endif

    repeat (4) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
